// File: rtl/microstep_pkg.sv
`default_nettype none
// ============================================================================
// microstep_pkg : shared types, constants and step arithmetic for the sequencer
// Rev 1.0
// ============================================================================
package microstep_pkg;

   localparam int STEPS_PER_CYCLE  = 256;
   localparam int FULL_STEP_COUNTS = 64;
   localparam int MAX_USTEP_SEL    = 6;
   localparam int POS_W            = $clog2(STEPS_PER_CYCLE);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } seq_state_t;

   typedef struct packed {
      logic       dir;
      logic [2:0] sel;
      logic       interp;
   } step_cmd_t;

   function automatic logic [6:0] step_inc(input logic [2:0] sel);
      logic [2:0] s;
      s = (sel > 3'(MAX_USTEP_SEL)) ? 3'(MAX_USTEP_SEL) : sel;
      return 7'(FULL_STEP_COUNTS) >> s;
   endfunction

   // Electrical position wraps naturally at POS_W bits.
   function automatic logic [POS_W-1:0] pos_move(input logic [POS_W-1:0] p,
                                                 input logic             up,
                                                 input logic [6:0]       amt);
      return up ? (p + POS_W'(amt)) : (p - POS_W'(amt));
   endfunction

endpackage
`default_nettype wire

// File: rtl/interp_timer.sv
`default_nettype none
// ============================================================================
// interp_timer : reloadable countdown that ticks every max(div,1) clocks
// Rev 1.0
// ============================================================================
module interp_timer #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             run,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] reload;

   assign reload = (div == '0) ? DIV_W'(1) : div;
   assign tick   = run && (cnt == DIV_W'(1));

   // div is sampled on every reload so changes apply from the next count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (load || tick) begin
         cnt <= reload;
      end else if (run) begin
         cnt <= cnt - DIV_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/microstep_sequencer.sv
`default_nettype none
// ============================================================================
// microstep_sequencer : step/dir commands to 8-bit phase position, with
// optional interpolation, one-deep pending buffer and sticky overrun. Rev 1.0
// ============================================================================
module microstep_sequencer
   import microstep_pkg::*;
#(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             step,
   input  logic             dir,
   input  logic [2:0]       ustep_sel,
   input  logic             interp_en,
   input  logic [DIV_W-1:0] interp_div,
   input  logic             clr_overrun,
   output logic [POS_W-1:0] pos,
   output logic             pos_upd,
   output logic             busy,
   output logic             overrun
);

   seq_state_t       state, state_n;
   logic             step_q;
   logic             step_edge;
   step_cmd_t        cmd_now, cmd;
   logic [POS_W-1:0] pos_n;
   logic             pos_upd_n;
   logic [6:0]       remaining, remaining_n;
   logic             run_dir, run_dir_n;
   logic             pend_valid, pend_valid_n;
   step_cmd_t        pend, pend_n;
   logic             overrun_n;
   logic             timer_load;
   logic             timer_run;
   logic             tick;
   logic             slot_free;
   logic             consumed;

   assign step_edge = step & ~step_q;
   assign cmd_now   = '{dir: dir, sel: ustep_sel, interp: interp_en};
   assign timer_run = enable && (state == RUN);

   interp_timer #(.DIV_W(DIV_W)) u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (timer_load),
      .run   (timer_run),
      .div   (interp_div),
      .tick  (tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n      = state;
      pos_n        = pos;
      pos_upd_n    = 1'b0;
      remaining_n  = remaining;
      run_dir_n    = run_dir;
      pend_valid_n = pend_valid;
      pend_n       = pend;
      overrun_n    = overrun & ~clr_overrun;
      timer_load   = 1'b0;
      cmd          = cmd_now;
      slot_free    = ~pend_valid;
      consumed     = 1'b0;

      if (!enable) begin
         state_n      = IDLE;
         pend_valid_n = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // A leftover pending command runs first; a fresh edge then takes its slot.
               if (pend_valid || step_edge) begin
                  cmd = pend_valid ? pend : cmd_now;
                  if (cmd.interp) begin
                     state_n     = RUN;
                     remaining_n = step_inc(cmd.sel);
                     run_dir_n   = cmd.dir;
                     timer_load  = 1'b1;
                  end else begin
                     pos_n     = pos_move(pos, cmd.dir, step_inc(cmd.sel));
                     pos_upd_n = 1'b1;
                  end
                  pend_valid_n = pend_valid && step_edge;
                  if (pend_valid && step_edge) begin
                     pend_n = cmd_now;
                  end
               end
            end
            RUN: begin
               if (tick) begin
                  pos_n       = pos_move(pos, run_dir, 7'd1);
                  pos_upd_n   = 1'b1;
                  remaining_n = remaining - 7'd1;
                  if (remaining == 7'd1) begin
                     if (pend_valid) begin
                        if (pend.interp) begin
                           remaining_n  = step_inc(pend.sel);
                           run_dir_n    = pend.dir;
                           pend_valid_n = 1'b0;
                           slot_free    = 1'b1;
                        end else begin
                           state_n = IDLE;
                        end
                     end else if (step_edge && cmd_now.interp) begin
                        remaining_n = step_inc(cmd_now.sel);
                        run_dir_n   = cmd_now.dir;
                        consumed    = 1'b1;
                     end else begin
                        state_n = IDLE;
                     end
                  end
               end
               if (step_edge && !consumed) begin
                  if (slot_free) begin
                     pend_valid_n = 1'b1;
                     pend_n       = cmd_now;
                  end else begin
                     overrun_n = 1'b1;
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_comb begin
      busy = (state == RUN);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step_q     <= 1'b0;
         pos        <= '0;
         pos_upd    <= 1'b0;
         remaining  <= '0;
         run_dir    <= 1'b0;
         pend_valid <= 1'b0;
         pend       <= '0;
         overrun    <= 1'b0;
      end else begin
         step_q     <= step;
         pos        <= pos_n;
         pos_upd    <= pos_upd_n;
         remaining  <= remaining_n;
         run_dir    <= run_dir_n;
         pend_valid <= pend_valid_n;
         pend       <= pend_n;
         overrun    <= overrun_n;
      end
   end

endmodule
`default_nettype wire

// File: doc/microstep_sequencer.md
Name: microstep_sequencer

Overview:
- Converts external step/dir commands into an 8-bit electrical phase position `pos`.
- One electrical cycle is 256 counts; one full step is 64 counts.
- `pos` feeds the phase decode / cosine lookup stage of the microstepper.
- Supports selectable microstep resolution, plus an optional interpolation mode that spreads one commanded step over timed single-count increments.
- Provides a one-deep pending buffer and a sticky overrun flag.

Parameters:
- DIV_W, 16, width of the interpolation interval divider.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  sequencer enable; low freezes `pos` and aborts activity
- step  input  1  step command, synchronous level; each rising edge is one command
- dir  input  1  1 = increment `pos`, 0 = decrement
- ustep_sel  input  3  resolution; step size = 64>>ustep_sel; 7 treated as 6
- interp_en  input  1  1 = interpolate each step as single-count moves
- interp_div  input  DIV_W  clocks between interpolated counts; 0 treated as 1
- clr_overrun  input  1  clears `overrun`
- pos  output  8  electrical phase position
- pos_upd  output  1  one-cycle pulse whenever `pos` changes
- busy  output  1  interpolation in progress
- overrun  output  1  sticky; a step command was dropped

Behaviour:
- Reset:
  - The reset value of every output is 0: `pos`, `pos_upd`, `busy`, `overrun`.
  - Internal state also resets: step edge register = 0, pending buffer empty, state = IDLE.
- Edge detect: `step_edge = step & ~step_q`, with `step_q` registered every cycle (also while `enable` is low).
- On acceptance, `dir`, `ustep_sel` and `interp_en` are sampled in the edge cycle.
- Step size `inc = 64 >> min(ustep_sel,6)`, range 1..64.
- Arithmetic: `pos` is modulo 256. 255+1 wraps to 0; 0-1 wraps to 255; a 64 jump from 224 gives 32.
- Direct mode (`interp_en` = 0 at acceptance, state IDLE):
  - The edge is seen in cycle N; `pos ± inc` appears after clock N+1.
  - `pos_upd` is high for that one cycle.
  - `busy` stays 0.
- FSM states: IDLE, RUN.
- IDLE:
  - A `step_edge` with `interp_en` = 1 loads `remaining = inc`, latched dir, and `timer = max(interp_div,1)`, then goes to RUN.
  - `busy` = 1 from the next cycle.
- RUN:
  - The timer decrements each cycle.
  - When the timer reaches 1: `pos ± 1`, `pos_upd` pulse, `remaining--`, timer reloads.
  - The first count occurs `max(interp_div,1)` cycles after entering RUN.
- RUN completion:
  - After the last count (`remaining` 1→0): if the pending buffer is full, load the pending command and stay in RUN. `busy` stays 1 and no idle gap is inserted.
  - Otherwise go to IDLE; `busy` = 0 the next cycle.
- Pending buffer:
  - A `step_edge` while in RUN is stored with its dir/sel/interp_en if the buffer is empty.
  - If the buffer is full, the command is dropped and `overrun` is set.
  - A pending command with interp_en = 0 executes as a single ±inc jump on completion, then the FSM returns to IDLE.
- Simultaneous events:
  - A `step_edge` in the same cycle as the final count with an empty buffer is loaded directly into RUN (or executed directly). No overrun.
  - `clr_overrun` together with a drop event leaves `overrun` = 1; set wins.
- `enable` low:
  - Edges are ignored (not buffered, no overrun).
  - RUN aborts to IDLE, remaining counts are discarded, pending is cleared, `busy` = 0 the next cycle.
  - `pos` holds its value.
  - Re-enabling does not generate a step from a `step` input that is already high.
- `interp_div` is sampled on each timer reload; changes take effect at the next count.
- Reset mid-operation returns all state to reset values immediately (asynchronous).

Decomposition:
- Shared package `microstep_pkg`:
  - `STEPS_PER_CYCLE`=256
  - `FULL_STEP_COUNTS`=64
  - `MAX_USTEP_SEL`=6
  - `seq_state_t` enum {IDLE, RUN}
  - `step_cmd_t` struct {dir, sel[2:0], interp}
- One natural sub-module: `interp_timer`. It holds the DIV_W reload/countdown and emits a tick; it is instantiated once.

Test Plan:
- Direct full steps: sel=0, interp_en=0, dir=1, 5 step edges → `pos` = 64,128,192,0,64, each one clock after its edge, with one `pos_upd` pulse each.
- Decrement wrap: sel=6, dir=0 from reset, 1 edge → `pos`=255, `busy` never asserted.
- Interpolation: sel=4 (inc 4), interp_div=3, dir=1 → `pos` 1,2,3,4 at 3-cycle spacing; `busy` goes high the cycle after the edge and low one cycle after the 4th count.
- Pending/overrun: interp_div=10, sel=2, 3 edges during RUN → 2nd command is buffered and runs back to back (`pos`=32 total, `busy` continuous); 3rd is dropped, `overrun`=1; `clr_overrun` pulse clears it.
- Abort: mid-RUN at `pos`=5 of 16, drop `enable` → `pos` holds 5, `busy`=0 next cycle, pending cleared; re-enable with `step` held high → no movement.
- Async reset asserted mid-RUN, between clock edges → all outputs 0 immediately; `interp_div`=0 run behaves as 1 count per cycle.
